// File: rtl/trn_chnnl_rr_merge.sv
// ---------------------------------------------------------------------------
// trn_chnnl_rr_merge
//   Merges NUM_CH AXI-Stream input channels into one output stream. Whole
//   packets are forwarded one at a time, and the source is chosen round-robin.
//   The enable, channel mask and maximum-length settings come from the
//   register bank. The packet counter and the length-error flag go back to it
//   as status.
//
//   Handshake: a beat moves on an interface in any cycle where valid and ready
//   are both 1 at the rising edge of ACLK. valid does not depend on ready. Once
//   m_axis_tvalid is raised, the beat and its data stay unchanged until
//   m_axis_tready accepts it.
//
// Ports
//   ACLK, ARESET         clock; asynchronous active-high reset
//   cfg_enable           global run, sampled in IDLE/ARB and at packet end
//   cfg_ch_mask          per-channel eligibility
//   cfg_max_len          beats allowed per packet (0 = unchecked)
//   s_axis_*             NUM_CH input channels (tdata packed per channel)
//   m_axis_*             merged output stream; tdest = source channel
//   stat_pkt_cnt         packets consumed at the output
//   stat_busy            FSM not in IDLE
//   stat_len_err         sticky over-length flag
//   stat_clr             pulse that clears stat_pkt_cnt and stat_len_err
// ---------------------------------------------------------------------------
module trn_chnnl_rr_merge #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic                     cfg_enable,
    input  logic [NUM_CH-1:0]        cfg_ch_mask,
    input  logic [CNT_W-1:0]         cfg_max_len,
    input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_CH-1:0]        s_axis_tvalid,
    input  logic [NUM_CH-1:0]        s_axis_tlast,
    output logic [NUM_CH-1:0]        s_axis_tready,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic [2:0]               m_axis_tdest,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [CNT_W-1:0]         stat_pkt_cnt,
    output logic                     stat_busy,
    output logic                     stat_len_err,
    input  logic                     stat_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [2:0]        grant;       // channel that owns the current packet
    logic [2:0]        ptr;         // last granted channel
    logic [2:0]        arb_sel;
    logic              arb_found;
    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic              out_free;
    logic              in_acc;
    logic              out_acc;
    logic              first_beat;
    logic [CNT_W-1:0]  beat_cnt;
    logic [CNT_W-1:0]  beat_nx;
    logic              len_over;
    logic              grant_now;

    // The output register can take a beat when it is empty or being drained.
    assign out_free  = !m_axis_tvalid || m_axis_tready;
    assign in_acc    = (state == XFER) && out_free && sel_valid;
    assign out_acc   = m_axis_tvalid && m_axis_tready;
    assign grant_now = (state == ARB) && cfg_enable && arb_found;
    assign stat_busy = (state != IDLE);

    // Select the granted channel and drive its ready. No other channel is
    // ever ready.
    always_comb begin
        sel_valid     = 1'b0;
        sel_last      = 1'b0;
        sel_data      = '0;
        s_axis_tready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == 3'(i)) begin
                sel_valid        = s_axis_tvalid[i];
                sel_last         = s_axis_tlast[i];
                sel_data         = s_axis_tdata[i*DATA_W +: DATA_W];
                s_axis_tready[i] = (state == XFER) && out_free;
            end
        end
    end

    // Round-robin search. The distance is measured from the channel just after
    // ptr, wrapping around. The eligible channel with the smallest distance
    // wins.
    always_comb begin
        int best;
        best      = NUM_CH;
        arb_sel   = '0;
        arb_found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch_mask[i] && s_axis_tvalid[i] &&
                (((i + 2*NUM_CH - 1 - int'(ptr)) % NUM_CH) < best)) begin
                best      = (i + 2*NUM_CH - 1 - int'(ptr)) % NUM_CH;
                arb_sel   = 3'(i);
                arb_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (cfg_enable) state_nx = ARB;
            ARB: begin
                if (!cfg_enable)    state_nx = IDLE;
                else if (arb_found) state_nx = XFER;
            end
            XFER: begin
                if (in_acc && sel_last) state_nx = cfg_enable ? ARB : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The beat count includes the beat being accepted. It saturates instead
    // of wrapping.
    always_comb begin
        if (first_beat)            beat_nx = CNT_W'(1);
        else if (beat_cnt == '1)   beat_nx = beat_cnt;
        else                       beat_nx = beat_cnt + CNT_W'(1);
    end

    // A beat that reaches the limit and is not the last beat means the packet
    // is longer than allowed.
    assign len_over = (cfg_max_len != '0) && (beat_nx == cfg_max_len) && !sel_last;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state      <= IDLE;
            grant      <= '0;
            ptr        <= 3'(NUM_CH - 1);
            first_beat <= 1'b0;
            beat_cnt   <= '0;
        end else begin
            state <= state_nx;
            if (grant_now) begin
                grant      <= arb_sel;
                ptr        <= arb_sel;
                first_beat <= 1'b1;
            end
            if (in_acc) begin
                first_beat <= 1'b0;
                beat_cnt   <= beat_nx;
            end
        end
    end

    // Single-entry output register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            m_axis_tdata  <= '0;
            m_axis_tdest  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else if (in_acc) begin
            m_axis_tdata  <= sel_data;
            m_axis_tdest  <= grant;
            m_axis_tlast  <= sel_last;
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Status. A clear takes priority over any update in the same cycle.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            stat_pkt_cnt <= '0;
            stat_len_err <= 1'b0;
        end else if (stat_clr) begin
            stat_pkt_cnt <= '0;
            stat_len_err <= 1'b0;
        end else begin
            if (out_acc && m_axis_tlast) stat_pkt_cnt <= stat_pkt_cnt + CNT_W'(1);
            if (in_acc && len_over)      stat_len_err <= 1'b1;
        end
    end

endmodule
